// File: rtl/ft64_shift_pkg.sv
// Shared definitions for the FT64 shift pipeline: opcode encoding,
// default shift-amount width and the fill pattern used when rotates are disabled.
package ft64_shift_pkg;

    typedef enum logic [2:0] {
        OP_SHL  = 3'd0,
        OP_SHR  = 3'd1,
        OP_ASL  = 3'd2,
        OP_ASR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } shift_op_e;

    localparam int unsigned DEF_WID   = 64;
    localparam int unsigned SW        = $clog2(DEF_WID);
    localparam logic [15:0] DEAD_FILL = 16'hDEAD;

    // The immediate bit (op[3]) never reaches this function, so immediate
    // forms decode to their register counterparts.
    function automatic shift_op_e decode_op(input logic [2:0] op_lo);
        return shift_op_e'(op_lo);
    endfunction

endpackage

// File: rtl/ft64_shift_core.sv
// Combinational shift datapath: overflow for the incoming operation and
// the result for the operation held in the first pipeline stage.
module ft64_shift_core
    import ft64_shift_pkg::*;
#(
    parameter int unsigned WID         = 64,
    parameter int unsigned ROTATE_INSN = 1
) (
    input  shift_op_e            ov_op_i,
    input  logic [WID-1:0]       ov_a_i,
    input  logic [$clog2(WID)-1:0] ov_n_i,
    output logic                 ov_o,
    input  shift_op_e            res_op_i,
    input  logic [WID-1:0]       res_a_i,
    input  logic [$clog2(WID)-1:0] res_n_i,
    output logic [WID-1:0]       res_o
);

    localparam int unsigned NW    = $clog2(WID);
    localparam logic [NW:0] WID_L = (NW+1)'(WID);

    logic [WID-1:0]        dead_s;
    logic [NW:0]           inv_s;
    logic signed [WID-1:0] asl_s;
    logic signed [WID-1:0] back_s;

    // DEAD pattern repeated across the word; narrow words keep the low bits.
    always_comb begin
        for (int i = 0; i < WID; i++) begin
            dead_s[i] = DEAD_FILL[4'(i)];
        end
    end

    // Shift back the left-shifted value; any difference means the sign did not survive.
    always_comb begin
        asl_s  = $signed(ov_a_i) <<< ov_n_i;
        back_s = asl_s >>> ov_n_i;
        if (ov_op_i == OP_ASL) begin
            ov_o = (back_s != $signed(ov_a_i));
        end else begin
            ov_o = 1'b0;
        end
    end

    // Result mux; n=0 rotates shift the complementary half by WID, giving zero.
    always_comb begin
        inv_s = WID_L - {1'b0, res_n_i};
        case (res_op_i)
            OP_SHL, OP_ASL: res_o = res_a_i << res_n_i;
            OP_SHR:         res_o = res_a_i >> res_n_i;
            OP_ASR:         res_o = $signed(res_a_i) >>> res_n_i;
            OP_ROL:         res_o = (ROTATE_INSN != 0) ? ((res_a_i << res_n_i) | (res_a_i >> inv_s)) : dead_s;
            OP_ROR:         res_o = (ROTATE_INSN != 0) ? ((res_a_i >> res_n_i) | (res_a_i << inv_s)) : dead_s;
            default:        res_o = {WID{1'b0}};
        endcase
    end

endmodule

// File: rtl/ft64_shift_pipe.sv
// Two-stage shift pipeline with valid/ready handshake: S1 holds the decoded
// operation and overflow, S2 is the output register holding result and tag.
module ft64_shift_pipe
    import ft64_shift_pkg::*;
#(
    parameter int unsigned WID         = 64,
    parameter int unsigned TAGW        = 5,
    parameter int unsigned ROTATE_INSN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [WID-1:0]  a,
    input  logic [WID-1:0]  b,
    input  logic [TAGW-1:0] tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WID-1:0]  res,
    output logic            ov,
    output logic [TAGW-1:0] out_tag
);

    localparam int unsigned NW = $clog2(WID);

    logic            s1_valid_q, s1_valid_d;
    shift_op_e       s1_op_q, s1_op_d;
    logic [WID-1:0]  s1_a_q, s1_a_d;
    logic [NW-1:0]   s1_n_q, s1_n_d;
    logic            s1_ov_q, s1_ov_d;
    logic [TAGW-1:0] s1_tag_q, s1_tag_d;

    logic            s2_valid_q, s2_valid_d;
    logic [WID-1:0]  res_q, res_d;
    logic            ov_q, ov_d;
    logic [TAGW-1:0] tag_q, tag_d;

    logic            s1_adv_s, s2_adv_s, accept_s;
    shift_op_e       op_dec_s;
    logic            core_ov_s;
    logic [WID-1:0]  core_res_s;
    logic            unused_bits_s;

    assign op_dec_s      = decode_op(op[2:0]);
    assign unused_bits_s = ^{op[3], b[WID-1:NW]};

    ft64_shift_core #(
        .WID         (WID),
        .ROTATE_INSN (ROTATE_INSN)
    ) u_core (
        .ov_op_i  (op_dec_s),
        .ov_a_i   (a),
        .ov_n_i   (b[NW-1:0]),
        .ov_o     (core_ov_s),
        .res_op_i (s1_op_q),
        .res_a_i  (s1_a_q),
        .res_n_i  (s1_n_q),
        .res_o    (core_res_s)
    );

    // A stage may load when empty or when the stage downstream is moving.
    always_comb begin
        s2_adv_s = !s2_valid_q || out_ready;
        s1_adv_s = !s1_valid_q || s2_adv_s;
        accept_s = in_valid && s1_adv_s;
    end

    assign in_ready  = s1_adv_s;
    assign out_valid = s2_valid_q;
    assign res       = res_q;
    assign ov        = ov_q;
    assign out_tag   = tag_q;

    // S1 next state: capture a new operation or drop to empty when it moves on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_n_d     = s1_n_q;
        s1_ov_d    = s1_ov_q;
        s1_tag_d   = s1_tag_q;
        if (s1_adv_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_op_d  = op_dec_s;
                s1_a_d   = a;
                s1_n_d   = b[NW-1:0];
                s1_ov_d  = core_ov_s;
                s1_tag_d = tag;
            end else begin
                s1_op_d  = s1_op_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2 next state: output fields change only when a valid S1 entry advances.
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        ov_d       = ov_q;
        tag_d      = tag_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = core_res_s;
                ov_d  = s1_ov_q;
                tag_d = s1_tag_q;
            end else begin
                res_d = res_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_SHL;
            s1_a_q     <= {WID{1'b0}};
            s1_n_q     <= {NW{1'b0}};
            s1_ov_q    <= 1'b0;
            s1_tag_q   <= {TAGW{1'b0}};
            s2_valid_q <= 1'b0;
            res_q      <= {WID{1'b0}};
            ov_q       <= 1'b0;
            tag_q      <= {TAGW{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_n_q     <= s1_n_d;
            s1_ov_q    <= s1_ov_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            ov_q       <= ov_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: doc/ft64_shift_pipe.md
FT64_SHIFT_PIPE -- requirements
Module: FT64_shift_pipe

Interface
REQ-001 Parameter WID, default 64: operand/result width; SHALL be a power of two, 8 to 128.
REQ-002 Parameter TAGW, default 5: width of the opaque tag carried with each operation.
REQ-003 Parameter ROTATE_INSN, default 1: 0 disables rotates; rotate results then equal {WID/16{16'hDEAD}}.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  unit accepts the operation this cycle.
REQ-008 op  input  4  shift opcode: SHL=0, SHR=1, ASL=2, ASR=3, ROL=4, ROR=5, immediate forms 8-D.
REQ-009 a  input  WID  operand to shift.
REQ-010 b  input  WID  shift amount; only b[$clog2(WID)-1:0] used.
REQ-011 tag  input  TAGW  tag returned with the result.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 res  output  WID  shifted result.
REQ-015 ov  output  1  arithmetic-left overflow flag.
REQ-016 out_tag  output  TAGW  tag of the presented result.

Function
REQ-017 Transfer SHALL occur on a cycle with in_valid && in_ready (accept) or out_valid && out_ready (retire).
REQ-018 The unit SHALL be a two-stage pipeline (S1, S2); S2 is the output register; each stage holds at most one operation.
REQ-019 Latency SHALL be exactly 2 cycles from accept to out_valid when out_ready is held high; throughput one operation per cycle.
REQ-020 in_ready SHALL equal !S1.valid || !S2.valid || out_ready (combinational; no bubble on stall release).
REQ-021 While out_valid && !out_ready, res, ov and out_tag SHALL be held stable.
REQ-022 op[3] SHALL be ignored; immediate forms behave as their register counterparts.
REQ-023 Let n = b mod WID. SHL/ASL: a << n, zero-fill. SHR: a >> n, zero-fill. ASR: a >> n, fill with a[WID-1].
REQ-024 ROL: (a << n) | (a >> (WID-n)); ROR: (a >> n) | (a << (WID-n)); n=0 SHALL return a unchanged.
REQ-025 ov SHALL be 1 only for ASL when n>0 and bits a[WID-1:WID-1-n] are not all equal; otherwise 0.
REQ-026 Opcodes 6, 7, E, F SHALL still flow through the pipe and retire with res=0, ov=0.
REQ-027 S1 SHALL register decoded op, n and ov; S2 SHALL register res and carry the tag unchanged.
REQ-028 Simultaneous accept and retire with both stages full SHALL advance both stages with no loss or duplication.
REQ-029 Results SHALL retire in acceptance order.

Reset
REQ-030 rst SHALL clear S1.valid and S2.valid and set res=0, ov=0, out_tag=0, out_valid=0 on the next edge.
REQ-031 Operations in flight at reset SHALL be discarded; an accept in the reset cycle SHALL be ignored.
REQ-032 in_ready SHALL be 1 the first cycle after reset deasserts.

Structure
REQ-033 Opcode enumeration, localparam SW=$clog2(WID) and the DEAD fill constant SHALL live in shared package FT64_shift_pkg.
REQ-034 The combinational result/overflow datapath SHALL be one sub-module, FT64_shift_core, parametrised by WID; handshake and registers stay in FT64_shift_pipe.

Verification (WID=64, TAGW=5)
REQ-035 ASR a=64'h8000_0000_0000_0010, b=4, tag=3, out_ready=1 -> 2 cycles later res=64'hF800_0000_0000_0001, ov=0, out_tag=3.
REQ-036 ASL a=64'h4000_0000_0000_0001, b=1 -> res=64'h8000_0000_0000_0002, ov=1; same with b=65 (n=1) -> identical; SHL a=1, b=0 -> res=1, ov=0.
REQ-037 ROL a=64'h8000_0000_0000_0001, b=1 -> res=3; ROR same a, b=0 -> res unchanged; ROTATE_INSN=0 build ROL -> res=64'hDEAD_DEAD_DEAD_DEAD.
REQ-038 Back-to-back 4 ops tags 0-3, out_ready low cycles 3-5 -> in_ready low while both stages full, res held stable, tags retire 0,1,2,3 with no loss.
REQ-039 Two ops in flight, rst pulsed 1 cycle -> out_valid=0, res=0 next cycle, in_ready=1 after reset, no stale result ever retires.
REQ-040 op=4'h7 a=64'hFFFF, b=3 -> retires after 2 cycles with res=0, ov=0.
